jogo_memoria_parametrizado: RTL and testbench
=============================================

Name: jogo_memoria_parametrizado

Overview:
Next-generation Simon-style game core. It is a sequence engine with internal sequence memory, generalised to NUM_BOTOES channels, PROF rounds and configurable timing. Each round it replays the stored sequence on leds, checks the player's presses against it, and enforces an optional timeout. A new write mode lets the player append the next sequence entry at the end of every round. It sits between the board button/LED pins and the top-level display/debug logic.

Parameters:
NUM_BOTOES, 4, number of buttons/LEDs (2..8)
PROF, 16, sequence memory depth = max rounds in normal mode (2..64)
LIMITE_DEMO, 4, round count in demo mode (1..PROF)
T_LED, 500, clock cycles an LED is lit during replay
T_APAGADO, 250, dark cycles between replayed LEDs
T_TIMEOUT, 5000, cycles allowed per player press when timeout is enabled

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
jogar  in  1  start/restart request, level sampled per cycle
configuracao  in  3  [0]=demo (LIMITE_DEMO rounds), [1]=timeout enable, [2]=write mode; latched on start
botoes  in  NUM_BOTOES  player buttons, already debounced
carga_we  in  1  preload write enable (honoured only in INICIAL)
carga_end  in  $clog2(PROF)  preload address
carga_dado  in  NUM_BOTOES  preload one-hot value
leds  out  NUM_BOTOES  replay / press echo
pronto  out  1  high in any final state
ganhou  out  1  win flag
perdeu  out  1  wrong-press flag
timeout  out  1  timeout-loss flag
rodada  out  $clog2(PROF+1)  current round, 1-based; 0 in INICIAL
db_estado  out  5  FSM state encoding

Behaviour:
- Reset: FSM to INICIAL; all outputs 0; counters and configuration latch cleared. Sequence memory is not cleared; contents survive reset.
- INICIAL: carga_we writes mem[carga_end] = carga_dado. jogar=1 latches configuracao, sets limite (LIMITE_DEMO if demo, else PROF) and rodada=1, then goes to PREPARA.
- PREPARA (1 cycle): end=0, then MOSTRA_LED.
- MOSTRA_LED: leds = mem[end] for exactly T_LED cycles, then MOSTRA_APAGADO.
- MOSTRA_APAGADO: leds=0 for T_APAGADO cycles. Then:
  - if end == rodada-1: end=0, go to ESPERA_JOGADA;
  - otherwise end+1, back to MOSTRA_LED.
- ESPERA_JOGADA: a press is a rising edge of |botoes, registered one cycle. The sampled botoes value is latched, and the state goes to COMPARA on the next cycle.
  - leds echo the latched value until release.
  - If no press occurs and timeout is enabled, the timeout counter reaching T_TIMEOUT-1 goes to FIM_TIMEOUT.
  - The timeout counter clears on entry to ESPERA_JOGADA and on every accepted press.
- COMPARA (1 cycle):
  - latched value != mem[end], including any multi-bit press: FIM_ERRO.
  - equal and end < rodada-1: end+1, back to ESPERA_JOGADA.
  - equal and end == rodada-1: FIM_RODADA.
- FIM_RODADA:
  - rodada == limite: FIM_ACERTO.
  - write mode and rodada < PROF: ESPERA_ESCRITA. The next valid single-bit press is written to mem[rodada]; a multi-bit press is ignored. The timeout rule applies here too.
  - otherwise: rodada+1, PREPARA.
- Final states:
  - FIM_ACERTO: ganhou=1.
  - FIM_ERRO: perdeu=1.
  - FIM_TIMEOUT: perdeu=1 and timeout=1.
  - All three set pronto=1, leds=0, and hold until jogar=1. jogar=1 clears the flags and goes to PREPARA with rodada=1 and freshly latched configuracao.
- Edge cases:
  - Press held across states is not re-counted; it needs a release and a new edge.
  - Press and timeout expiring in the same cycle: the press wins.
  - jogar is ignored outside INICIAL and the final states.
  - reset mid-game: back to INICIAL with no flags asserted.
- Widths: all counters sized with $clog2 of their terminal value plus 1. No wrap is reachable, because end never exceeds PROF-1.

Decomposition:
- Package jogo_memoria_pkg holds:
  - the state encoding constants (5-bit: INICIAL=0, PREPARA=1, MOSTRA_LED=3, MOSTRA_APAGADO=5, ESPERA_JOGADA=7, COMPARA=8, FIM_RODADA=9, ESPERA_ESCRITA=10, FIM_ACERTO=14, FIM_TIMEOUT=15, FIM_ERRO=16);
  - the configuracao bit indices.
- One sub-module, contador_limite (parametrised width/terminal, clear/enable, terminal flag). It is instantiated for T_LED, T_APAGADO, T_TIMEOUT, end and rodada.
- The FSM and the memory array stay in the top module.

Test Plan:
- NUM_BOTOES=4, LIMITE_DEMO=2, T_LED=4, T_APAGADO=2. Preload mem[0]=0001 and mem[1]=0100, config 001, jogar. Round 1: leds=0001 for 4 cycles; press 0001. Round 2: replay both, press 0001 then 0100. Expect ganhou=1, pronto=1, perdeu=0, rodada=2.
- Same preload, config 000. Round 2: press 0001 then 1000. Expect perdeu=1, timeout=0, db_estado=16, one cycle after COMPARA.
- config 011, T_TIMEOUT=20. After round 1 replay, no press. Expect timeout=perdeu=1 exactly 20 cycles after entering ESPERA_JOGADA; db_estado=15.
- config 101. Round 1 correct; in ESPERA_ESCRITA press 0010. Expect mem[1]=0010 and round 2 replay shows 0001, 0010.
- Press 0011 in ESPERA_JOGADA -> perdeu=1. Mid-replay reset -> all outputs 0, rodada=0, and mem contents unchanged on the next game.
- Final state, jogar=1 -> flags clear, rodada=1, replay restarts; a held button does not count as a press.

Source files
------------

// File: rtl/jogo_memoria_pkg.sv
// Shared constants for the memory game core: state encoding, config bits
// and a counter width helper.
package jogo_memoria_pkg;

  localparam logic [4:0] INICIAL        = 5'd0;
  localparam logic [4:0] PREPARA        = 5'd1;
  localparam logic [4:0] MOSTRA_LED     = 5'd3;
  localparam logic [4:0] MOSTRA_APAGADO = 5'd5;
  localparam logic [4:0] ESPERA_JOGADA  = 5'd7;
  localparam logic [4:0] COMPARA        = 5'd8;
  localparam logic [4:0] FIM_RODADA     = 5'd9;
  localparam logic [4:0] ESPERA_ESCRITA = 5'd10;
  localparam logic [4:0] FIM_ACERTO     = 5'd14;
  localparam logic [4:0] FIM_TIMEOUT    = 5'd15;
  localparam logic [4:0] FIM_ERRO       = 5'd16;

  // configuracao bit positions
  localparam int CFG_DEMO    = 0;
  localparam int CFG_TIMEOUT = 1;
  localparam int CFG_ESCRITA = 2;

  // Bits needed to hold values 0..fim (at least one bit).
  function automatic int largura(input int fim);
    return (fim < 1) ? 1 : $clog2(fim + 1);
  endfunction

endpackage

// File: rtl/contador_limite.sv
// Up counter with clear/increment that saturates at FIM and flags it.
// Clear together with increment restarts the count at 1.
module contador_limite
  import jogo_memoria_pkg::*;
#(
  parameter int FIM = 1,
  parameter int W   = largura(FIM)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q,
  output logic         o_fim
);

  assign o_fim = (o_q == W'(FIM));

  // count register: clear has priority, never counts past the terminal
  always_ff @(posedge clock) begin
    if (reset)                o_q <= '0;
    else if (i_clr)           o_q <= W'(i_inc);
    else if (i_inc && !o_fim) o_q <= o_q + 1'b1;
  end

endmodule

// File: rtl/jogo_memoria_parametrizado.sv
// Simon-style sequence engine: replays the stored sequence on leds, checks
// player presses, optional per-press timeout and optional append mode.
module jogo_memoria_parametrizado
  import jogo_memoria_pkg::*;
#(
  parameter int NUM_BOTOES  = 4,
  parameter int PROF        = 16,
  parameter int LIMITE_DEMO = 4,
  parameter int T_LED       = 500,
  parameter int T_APAGADO   = 250,
  parameter int T_TIMEOUT   = 5000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      jogar,
  input  logic [2:0]                configuracao,
  input  logic [NUM_BOTOES-1:0]     botoes,
  input  logic                      carga_we,
  input  logic [$clog2(PROF)-1:0]   carga_end,
  input  logic [NUM_BOTOES-1:0]     carga_dado,
  output logic [NUM_BOTOES-1:0]     leds,
  output logic                      pronto,
  output logic                      ganhou,
  output logic                      perdeu,
  output logic                      timeout,
  output logic [$clog2(PROF+1)-1:0] rodada,
  output logic [4:0]                db_estado
);

  localparam int AW = largura(PROF - 1);
  localparam int RW = largura(PROF);

  logic [4:0]            r_estado;
  logic [NUM_BOTOES-1:0] r_mem [PROF];
  logic [2:0]            r_cfg;
  logic                  r_bot_ant;
  logic                  r_eco;
  logic [NUM_BOTOES-1:0] r_jogada;

  logic [AW-1:0] w_end;
  logic [RW-1:0] w_rod;
  logic [RW-1:0] w_limite;
  logic          w_led_fim, w_apag_fim, w_to_fim, w_rod_fim;
  logic          w_unused_end_fim;
  logic [largura(T_LED-1)-1:0]     w_unused_q_led;
  logic [largura(T_APAGADO-1)-1:0] w_unused_q_apag;
  logic [largura(T_TIMEOUT-1)-1:0] w_unused_q_to;
  logic w_final, w_inicia, w_borda, w_unico, w_ultimo, w_igual;
  logic w_aceita_jog, w_aceita_esc, w_espera, w_avanca;
  logic w_end_clr, w_end_inc, w_rod_inc;

  assign w_final  = (r_estado == FIM_ACERTO) || (r_estado == FIM_TIMEOUT) ||
                    (r_estado == FIM_ERRO);
  assign w_inicia = jogar && ((r_estado == INICIAL) || w_final);
  assign w_limite = r_cfg[CFG_DEMO] ? RW'(LIMITE_DEMO) : RW'(PROF);
  // a press is a new rising edge of any button; holds never re-trigger
  assign w_borda  = (|botoes) && !r_bot_ant;
  assign w_unico  = (|botoes) && ((botoes & (botoes - 1'b1)) == '0);
  assign w_ultimo = ((RW'(w_end) + RW'(1)) == w_rod);
  assign w_igual  = (r_jogada == r_mem[w_end]);
  assign w_espera = (r_estado == ESPERA_JOGADA) || (r_estado == ESPERA_ESCRITA);
  assign w_aceita_jog = (r_estado == ESPERA_JOGADA) && w_borda;
  assign w_aceita_esc = (r_estado == ESPERA_ESCRITA) && w_borda && w_unico;
  // round finished without winning and without an append step
  assign w_avanca = (r_estado == FIM_RODADA) && (w_rod != w_limite) &&
                    !(r_cfg[CFG_ESCRITA] && !w_rod_fim);

  assign w_end_clr = (r_estado == PREPARA) ||
                     ((r_estado == MOSTRA_APAGADO) && w_apag_fim && w_ultimo);
  assign w_end_inc = ((r_estado == MOSTRA_APAGADO) && w_apag_fim && !w_ultimo) ||
                     ((r_estado == COMPARA) && w_igual && !w_ultimo);
  assign w_rod_inc = w_inicia || w_avanca || w_aceita_esc;

  contador_limite #(.FIM(T_LED - 1)) u_t_led (
    .clock(clock), .reset(reset),
    .i_clr(r_estado != MOSTRA_LED), .i_inc(r_estado == MOSTRA_LED),
    .o_q(w_unused_q_led), .o_fim(w_led_fim)
  );

  contador_limite #(.FIM(T_APAGADO - 1)) u_t_apagado (
    .clock(clock), .reset(reset),
    .i_clr(r_estado != MOSTRA_APAGADO), .i_inc(r_estado == MOSTRA_APAGADO),
    .o_q(w_unused_q_apag), .o_fim(w_apag_fim)
  );

  contador_limite #(.FIM(T_TIMEOUT - 1)) u_t_timeout (
    .clock(clock), .reset(reset),
    .i_clr(!w_espera || w_aceita_jog || w_aceita_esc), .i_inc(w_espera),
    .o_q(w_unused_q_to), .o_fim(w_to_fim)
  );

  contador_limite #(.FIM(PROF - 1)) u_end (
    .clock(clock), .reset(reset),
    .i_clr(w_end_clr), .i_inc(w_end_inc),
    .o_q(w_end), .o_fim(w_unused_end_fim)
  );

  // start clears and increments together so rodada restarts at 1
  contador_limite #(.FIM(PROF)) u_rodada (
    .clock(clock), .reset(reset),
    .i_clr(w_inicia), .i_inc(w_rod_inc),
    .o_q(w_rod), .o_fim(w_rod_fim)
  );

  // sequence memory: preload while idle, append in write mode; never reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      if ((r_estado == INICIAL) && carga_we) r_mem[carga_end] <= carga_dado;
      else if (w_aceita_esc)                 r_mem[w_rod[AW-1:0]] <= botoes;
    end
  end

  // press capture, echo tracking and configuration latch
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bot_ant <= 1'b0;
      r_eco     <= 1'b0;
      r_jogada  <= '0;
      r_cfg     <= '0;
    end else begin
      r_bot_ant <= |botoes;
      if (w_aceita_jog || w_aceita_esc) begin
        r_eco    <= 1'b1;
        r_jogada <= botoes;
      end else if (!(|botoes)) begin
        r_eco <= 1'b0;
      end
      if (w_inicia) r_cfg <= configuracao;
    end
  end

  // game FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      case (r_estado)
        INICIAL:        if (jogar) r_estado <= PREPARA;
        PREPARA:        r_estado <= MOSTRA_LED;
        MOSTRA_LED:     if (w_led_fim) r_estado <= MOSTRA_APAGADO;
        MOSTRA_APAGADO: if (w_apag_fim) r_estado <= w_ultimo ? ESPERA_JOGADA : MOSTRA_LED;
        ESPERA_JOGADA: begin
          if (w_borda)                              r_estado <= COMPARA;
          else if (r_cfg[CFG_TIMEOUT] && w_to_fim) r_estado <= FIM_TIMEOUT;
        end
        COMPARA: begin
          if (!w_igual)      r_estado <= FIM_ERRO;
          else if (w_ultimo) r_estado <= FIM_RODADA;
          else               r_estado <= ESPERA_JOGADA;
        end
        FIM_RODADA: begin
          if (w_rod == w_limite)                    r_estado <= FIM_ACERTO;
          else if (r_cfg[CFG_ESCRITA] && !w_rod_fim) r_estado <= ESPERA_ESCRITA;
          else                                      r_estado <= PREPARA;
        end
        ESPERA_ESCRITA: begin
          if (w_aceita_esc)                        r_estado <= PREPARA;
          else if (r_cfg[CFG_TIMEOUT] && w_to_fim) r_estado <= FIM_TIMEOUT;
        end
        FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: if (jogar) r_estado <= PREPARA;
        default:        r_estado <= INICIAL;
      endcase
    end
  end

  // leds show the replayed entry, or echo the captured press until release
  always_comb begin
    leds = '0;
    case (r_estado)
      MOSTRA_LED: leds = r_mem[w_end];
      ESPERA_JOGADA, COMPARA, FIM_RODADA, ESPERA_ESCRITA:
        if (r_eco) leds = r_jogada;
      default: leds = '0;
    endcase
  end

  assign pronto    = w_final;
  assign ganhou    = (r_estado == FIM_ACERTO);
  assign perdeu    = (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
  assign timeout   = (r_estado == FIM_TIMEOUT);
  assign rodada    = w_rod;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_jogo_memoria_parametrizado.sv
// Directed, table-driven bench for the memory game core.
module tb_jogo_memoria_parametrizado;

  localparam logic [4:0] S_INI = 5'd0,  S_PREP = 5'd1,  S_LED = 5'd3,  S_APAG = 5'd5;
  localparam logic [4:0] S_ESP = 5'd7,  S_CMP = 5'd8,   S_FROD = 5'd9, S_ESC = 5'd10;
  localparam logic [4:0] S_WIN = 5'd14, S_TO = 5'd15,   S_ERR = 5'd16;

  logic       clock = 1'b0;
  logic       reset, jogar, carga_we;
  logic [2:0] configuracao;
  logic [3:0] botoes, carga_end, carga_dado, leds;
  logic       pronto, ganhou, perdeu, timeout;
  logic [4:0] rodada, db_estado;

  int n_aval   = 0;
  int n_falhas = 0;

  jogo_memoria_parametrizado #(
    .NUM_BOTOES(4), .PROF(16), .LIMITE_DEMO(2),
    .T_LED(4), .T_APAGADO(2), .T_TIMEOUT(20)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
    .botoes(botoes), .carga_we(carga_we), .carga_end(carga_end),
    .carga_dado(carga_dado), .leds(leds), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .timeout(timeout), .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nome;
    int         n;
    logic       rst, jog, we;
    logic [2:0] cfg;
    logic [3:0] bot, ende, dado;
    logic [4:0] e_est;
    logic [3:0] e_leds;
    logic [4:0] e_rod;
    logic [3:0] e_flg;   // {pronto, ganhou, perdeu, timeout}
  } vec_t;

  vec_t tab[$];

  function automatic void vf(string nm, int n, logic rst, logic jog, logic [2:0] cfg,
                             logic [3:0] bot, logic we, logic [3:0] ende, logic [3:0] dado,
                             logic [4:0] est, logic [3:0] lds, logic [4:0] rod);
    vec_t r;
    r.nome = nm; r.n = n; r.rst = rst; r.jog = jog; r.cfg = cfg; r.bot = bot;
    r.we = we; r.ende = ende; r.dado = dado; r.e_est = est; r.e_leds = lds; r.e_rod = rod;
    case (est)
      S_WIN:   r.e_flg = 4'b1100;
      S_ERR:   r.e_flg = 4'b1010;
      S_TO:    r.e_flg = 4'b1011;
      default: r.e_flg = 4'b0000;
    endcase
    tab.push_back(r);
  endfunction

  function automatic void v(string nm, int n, logic jog, logic [2:0] cfg, logic [3:0] bot,
                            logic [4:0] est, logic [3:0] lds, logic [4:0] rod);
    vf(nm, n, 1'b0, jog, cfg, bot, 1'b0, 4'd0, 4'd0, est, lds, rod);
  endfunction

  // one replayed entry: lit for 4 cycles then dark for 2
  function automatic void mostra(string nm, logic [3:0] val, logic [4:0] rod, logic [3:0] bot);
    v(nm, 4, 1'b0, 3'b000, bot, S_LED, val, rod);
    v(nm, 2, 1'b0, 3'b000, bot, S_APAG, 4'd0, rod);
  endfunction

  // press for one cycle (echoed in COMPARA), then release
  function automatic void aperta(string nm, logic [3:0] val, logic [4:0] rod, logic [4:0] depois);
    v(nm, 1, 1'b0, 3'b000, val, S_CMP, val, rod);
    v(nm, 1, 1'b0, 3'b000, 4'd0, depois, 4'd0, rod);
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_aval++;
    if (a !== e) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic aplica(vec_t r);
    for (int c = 0; c < r.n; c++) begin
      reset = r.rst; jogar = r.jog; configuracao = r.cfg; botoes = r.bot;
      carga_we = r.we; carga_end = r.ende; carga_dado = r.dado;
      @(posedge clock); #1;
      n_aval++;
      if (db_estado !== r.e_est || leds !== r.e_leds || rodada !== r.e_rod ||
          {pronto, ganhou, perdeu, timeout} !== r.e_flg) begin
        n_falhas++;
        $display("FAIL %s cycle %0d: estado=%0d leds=%b rodada=%0d flags=%b, expected estado=%0d leds=%b rodada=%0d flags=%b",
                 r.nome, c, db_estado, leds, rodada, {pronto, ganhou, perdeu, timeout},
                 r.e_est, r.e_leds, r.e_rod, r.e_flg);
      end
    end
  endtask

  initial begin
    reset = 1'b1; jogar = 1'b0; configuracao = 3'b000; botoes = 4'd0;
    carga_we = 1'b0; carga_end = 4'd0; carga_dado = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_leds", 32'(leds), 0);
    chk("rst_pronto", 32'(pronto), 0);
    chk("rst_ganhou", 32'(ganhou), 0);
    chk("rst_perdeu", 32'(perdeu), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_rodada", 32'(rodada), 0);
    chk("rst_estado", 32'(db_estado), 32'(S_INI));

    // preload mem[0]=0001, mem[1]=0100
    vf("carga0", 1, 0, 0, 3'b000, 4'd0, 1, 4'd0, 4'b0001, S_INI, 4'd0, 5'd0);
    vf("carga1", 1, 0, 0, 3'b000, 4'd0, 1, 4'd1, 4'b0100, S_INI, 4'd0, 5'd0);

    // demo game, correct play -> win
    v("t1_start", 1, 1, 3'b001, 4'd0, S_PREP, 4'd0, 5'd1);
    mostra("t1_r1", 4'b0001, 5'd1, 4'd0);
    v("t1_esp_jogar_ign", 1, 1, 3'b000, 4'd0, S_ESP, 4'd0, 5'd1);
    aperta("t1_r1_p0", 4'b0001, 5'd1, S_FROD);
    v("t1_prox", 1, 0, 3'b000, 4'd0, S_PREP, 4'd0, 5'd2);
    mostra("t1_r2a", 4'b0001, 5'd2, 4'd0);
    mostra("t1_r2b", 4'b0100, 5'd2, 4'd0);
    v("t1_r2_esp", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd2);
    aperta("t1_r2_p0", 4'b0001, 5'd2, S_ESP);
    aperta("t1_r2_p1", 4'b0100, 5'd2, S_FROD);
    v("t1_ganhou", 3, 0, 3'b000, 4'd0, S_WIN, 4'd0, 5'd2);

    // normal game, wrong second press; preload ignored mid-game
    v("t2_start", 1, 1, 3'b000, 4'd0, S_PREP, 4'd0, 5'd1);
    mostra("t2_r1", 4'b0001, 5'd1, 4'd0);
    vf("t2_carga_ign", 1, 0, 0, 3'b000, 4'd0, 1, 4'd0, 4'b1000, S_ESP, 4'd0, 5'd1);
    aperta("t2_r1_p0", 4'b0001, 5'd1, S_FROD);
    v("t2_prox", 1, 0, 3'b000, 4'd0, S_PREP, 4'd0, 5'd2);
    mostra("t2_r2a", 4'b0001, 5'd2, 4'd0);
    mostra("t2_r2b", 4'b0100, 5'd2, 4'd0);
    v("t2_r2_esp", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd2);
    aperta("t2_r2_p0", 4'b0001, 5'd2, S_ESP);
    aperta("t2_r2_p1_errado", 4'b1000, 5'd2, S_ERR);
    v("t2_erro_hold", 1, 0, 3'b000, 4'd0, S_ERR, 4'd0, 5'd2);

    // timeout after exactly 20 cycles of waiting
    v("t3_start", 1, 1, 3'b011, 4'd0, S_PREP, 4'd0, 5'd1);
    mostra("t3_r1", 4'b0001, 5'd1, 4'd0);
    v("t3_espera", 20, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd1);
    v("t3_timeout", 3, 0, 3'b000, 4'd0, S_TO, 4'd0, 5'd1);

    // press on the expiring cycle wins; counter restarts per press
    v("t3b_start", 1, 1, 3'b011, 4'd0, S_PREP, 4'd0, 5'd1);
    mostra("t3b_r1", 4'b0001, 5'd1, 4'd0);
    v("t3b_espera", 20, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd1);
    aperta("t3b_press_ganha", 4'b0001, 5'd1, S_FROD);
    v("t3b_prox", 1, 0, 3'b000, 4'd0, S_PREP, 4'd0, 5'd2);
    mostra("t3b_r2a", 4'b0001, 5'd2, 4'd0);
    mostra("t3b_r2b", 4'b0100, 5'd2, 4'd0);
    v("t3b_espera2", 10, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd2);
    aperta("t3b_p0", 4'b0001, 5'd2, S_ESP);
    v("t3b_espera3", 19, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd2);
    v("t3b_timeout", 1, 0, 3'b000, 4'd0, S_TO, 4'd0, 5'd2);

    // write mode: append 0010 as entry 1 (multi-bit press ignored)
    v("t4_start", 1, 1, 3'b101, 4'd0, S_PREP, 4'd0, 5'd1);
    mostra("t4_r1", 4'b0001, 5'd1, 4'd0);
    v("t4_esp", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd1);
    aperta("t4_r1_p0", 4'b0001, 5'd1, S_FROD);
    v("t4_escrita", 1, 0, 3'b000, 4'd0, S_ESC, 4'd0, 5'd1);
    v("t4_multibit_ign", 1, 0, 3'b000, 4'b0011, S_ESC, 4'd0, 5'd1);
    v("t4_solta", 1, 0, 3'b000, 4'd0, S_ESC, 4'd0, 5'd1);
    v("t4_grava", 1, 0, 3'b000, 4'b0010, S_PREP, 4'd0, 5'd2);
    mostra("t4_r2a", 4'b0001, 5'd2, 4'd0);
    mostra("t4_r2b_novo", 4'b0010, 5'd2, 4'd0);
    v("t4_r2_esp", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd2);
    aperta("t4_r2_p0", 4'b0001, 5'd2, S_ESP);
    aperta("t4_r2_p1", 4'b0010, 5'd2, S_FROD);
    v("t4_ganhou", 1, 0, 3'b000, 4'd0, S_WIN, 4'd0, 5'd2);

    // multi-bit press in play is an error
    v("t5_start", 1, 1, 3'b001, 4'd0, S_PREP, 4'd0, 5'd1);
    mostra("t5_r1", 4'b0001, 5'd1, 4'd0);
    v("t5_esp", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd1);
    aperta("t5_multibit", 4'b0011, 5'd1, S_ERR);

    // reset mid-replay, memory survives
    v("t5r_start", 1, 1, 3'b001, 4'd0, S_PREP, 4'd0, 5'd1);
    v("t5r_led", 2, 0, 3'b000, 4'd0, S_LED, 4'b0001, 5'd1);
    vf("t5r_reset", 2, 1, 1, 3'b001, 4'd0, 0, 4'd0, 4'd0, S_INI, 4'd0, 5'd0);
    v("t5r_idle", 1, 0, 3'b000, 4'd0, S_INI, 4'd0, 5'd0);
    v("t5r_novo", 1, 1, 3'b001, 4'd0, S_PREP, 4'd0, 5'd1);
    mostra("t5r_r1", 4'b0001, 5'd1, 4'd0);
    v("t5r_esp", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd1);
    aperta("t5r_r1_p0", 4'b0001, 5'd1, S_FROD);
    v("t5r_prox", 1, 0, 3'b000, 4'd0, S_PREP, 4'd0, 5'd2);
    mostra("t5r_r2a", 4'b0001, 5'd2, 4'd0);
    mostra("t5r_r2b_mem", 4'b0010, 5'd2, 4'd0);
    v("t5r_r2_esp", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd2);
    aperta("t5r_r2_p0", 4'b0001, 5'd2, S_ESP);
    aperta("t5r_r2_p1", 4'b0010, 5'd2, S_FROD);
    v("t5r_ganhou", 1, 0, 3'b000, 4'd0, S_WIN, 4'd0, 5'd2);

    // restart from final state with a button held: hold is not a press
    v("t6_restart", 1, 1, 3'b001, 4'b1000, S_PREP, 4'd0, 5'd1);
    mostra("t6_r1", 4'b0001, 5'd1, 4'b1000);
    v("t6_segura", 4, 0, 3'b000, 4'b1000, S_ESP, 4'd0, 5'd1);
    v("t6_solta", 1, 0, 3'b000, 4'd0, S_ESP, 4'd0, 5'd1);
    aperta("t6_p0", 4'b0001, 5'd1, S_FROD);
    v("t6_prox", 1, 0, 3'b000, 4'd0, S_PREP, 4'd0, 5'd2);

    foreach (tab[i]) aplica(tab[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
    $finish;
  end

endmodule
